// File: rtl/satd_vertical_acc.sv
// Vertical 8-point Hadamard over 8x8 sub-blocks, |coef| summed across HEIGHT rows.
// Define SATD_NORM_EN for a rounded satd/4 output instead of the raw sum.
module satd_vertical_acc #(
  parameter int LENGTH = 8,
  parameter int HEIGHT = 16
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic signed [LENGTH+3:0]             hth_0,
  input  logic signed [LENGTH+3:0]             hth_1,
  input  logic signed [LENGTH+3:0]             hth_2,
  input  logic signed [LENGTH+3:0]             hth_3,
  input  logic signed [LENGTH+3:0]             hth_4,
  input  logic signed [LENGTH+3:0]             hth_5,
  input  logic signed [LENGTH+3:0]             hth_6,
  input  logic signed [LENGTH+3:0]             hth_7,
  output logic [LENGTH+6+$clog2(8*HEIGHT):0]   satd,
  output logic                                 satd_valid,
  input  logic                                 satd_ready
);
  localparam int W  = LENGTH + 4;
  localparam int HW = W + 3;
  localparam int SW = HW + 3;
  localparam int AW = LENGTH + 7 + $clog2(8*HEIGHT);
  localparam int NB = HEIGHT / 8;
  localparam int BW = $clog2(NB + 1);
  localparam logic [BW-1:0] BLK_LAST = BW'(NB - 1);

  localparam logic [1:0] FILL  = 2'd0;
  localparam logic [1:0] XFORM = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]          state;
  logic [2:0]          row_cnt;
  logic [2:0]          col_cnt;
  logic [BW-1:0]       blk_cnt;
  logic [AW-1:0]       acc;
  logic signed [W-1:0] tbuf [8][8];
  logic signed [W-1:0] row [8];
  logic signed [HW-1:0] s0 [8];
  logic signed [HW-1:0] s1 [8];
  logic signed [HW-1:0] s2 [8];
  logic signed [HW-1:0] s3 [8];
  logic [HW-1:0]       mag [8];
  logic [SW-1:0]       colsum;
  logic                xfer;

  assign in_ready   = (state == FILL);
  assign satd_valid = (state == DONE);
  assign xfer       = in_valid && in_ready;

  // Three butterfly stages on column col_cnt of the transpose buffer
  always_comb begin
    row = '{hth_0, hth_1, hth_2, hth_3,
            hth_4, hth_5, hth_6, hth_7};
    for (int i = 0; i < 8; i++) begin
      s0[i] = HW'(tbuf[i][col_cnt]);
    end
    for (int i = 0; i < 4; i++) begin
      s1[i]   = s0[i] + s0[i+4];
      s1[i+4] = s0[i] - s0[i+4];
    end
    for (int i = 0; i < 8; i += 4) begin
      for (int j = 0; j < 2; j++) begin
        s2[i+j]   = s1[i+j] + s1[i+j+2];
        s2[i+j+2] = s1[i+j] - s1[i+j+2];
      end
    end
    for (int i = 0; i < 8; i += 2) begin
      s3[i]   = s2[i] + s2[i+1];
      s3[i+1] = s2[i] - s2[i+1];
    end
    colsum = '0;
    for (int i = 0; i < 8; i++) begin
      // -(-2^(HW-1)) wraps to 2^(HW-1), read back unsigned it is exact
      mag[i] = s3[i][HW-1] ? $unsigned(-s3[i])
                           : $unsigned(s3[i]);
      colsum = colsum + SW'(mag[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= FILL;
      row_cnt <= '0;
      col_cnt <= '0;
      blk_cnt <= '0;
      acc     <= '0;
    end else begin
      unique case (1'b1)
        (state == FILL): begin
          if (in_valid) begin
            row_cnt <= row_cnt + 3'd1;
            if (row_cnt == 3'd7) begin
              state   <= XFORM;
              col_cnt <= '0;
            end
          end
        end
        (state == XFORM): begin
          acc     <= acc + AW'(colsum);
          col_cnt <= col_cnt + 3'd1;
          if (col_cnt == 3'd7) begin
            if (blk_cnt == BLK_LAST) begin
              state <= DONE;
            end else begin
              state   <= FILL;
              blk_cnt <= blk_cnt + BW'(1);
            end
          end
        end
        (state == DONE): begin
          if (satd_ready) begin
            state   <= FILL;
            acc     <= '0;
            blk_cnt <= '0;
          end
        end
        default: state <= FILL;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (xfer) begin
      tbuf[row_cnt] <= row;
    end
  end

`ifdef SATD_NORM_EN
  logic [AW:0] rnd;
  assign rnd  = {1'b0, acc} + (AW+1)'(2);
  assign satd = AW'(rnd >> 2);
`else
  assign satd = acc;
`endif

endmodule
